// File: rtl/pio_dac_spi_tx.sv
// PIO-triggered SPI DAC transmitter: toggling bit 31 of the PIO word sends one
// MSB-first SPI frame (mode 0), then an LDAC load pulse, then a chip-select gap.
module pio_dac_spi_tx #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned FRAME_BITS  = 24,
  parameter int unsigned LDAC_CYCLES = 2,
  parameter int unsigned CS_GAP      = 2,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pio_word,
  input  logic                   overrun_clr,
  output logic                   dac_sclk,
  output logic                   dac_cs_n,
  output logic                   dac_mosi,
  output logic                   dac_ldac_n,
  output logic                   busy,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned MAX_AB    = (CLK_DIV > LDAC_CYCLES) ? CLK_DIV : LDAC_CYCLES;
  localparam int unsigned MAX_PHASE = (MAX_AB > CS_GAP) ? MAX_AB : CS_GAP;
  localparam int unsigned CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int unsigned BIT_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_LDAC,
    ST_GAP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   pend_word_q, pend_word_d;
  logic                    pending_q, pending_d;
  logic                    prev_trig_q;
  logic                    overrun_q, overrun_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic                    mosi_q, mosi_d;
  logic                    ldac_n_q, ldac_n_d;
  logic                    busy_q, busy_d;

  logic                    trig_c;
  logic [FRAME_BITS-1:0]   payload_c;
  logic [FRAME_BITS-1:0]   launch_word_c;
  logic [FRAME_BITS-1:0]   shifted_c;
  logic                    direct_ok_c;
  logic [31:0]             unused_pio;

  // Trigger edge detect and payload selection
  assign trig_c        = pio_word[31] ^ prev_trig_q;
  assign payload_c     = pio_word[FRAME_BITS-1:0];
  assign launch_word_c = pending_q ? pend_word_q : payload_c;
  assign shifted_c     = shift_q << 1;
  assign direct_ok_c   = (state_q == ST_IDLE) && !pending_q;
  assign unused_pio    = pio_word;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pend_word_q <= '0;
      pending_q   <= 1'b0;
      prev_trig_q <= 1'b1;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ldac_n_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pend_word_q <= pend_word_d;
      pending_q   <= pending_d;
      prev_trig_q <= pio_word[31];
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      ldac_n_q    <= ldac_n_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pend_word_d = pend_word_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    ldac_n_d    = ldac_n_q;

    case (state_q)
      ST_IDLE: begin
        if (pending_q || trig_c) begin
          state_d  = ST_SETUP;
          shift_d  = launch_word_c;
          cnt_d    = CNT_W'(CLK_DIV - 1);
          cs_n_d   = 1'b0;
          sclk_d   = 1'b0;
          mosi_d   = launch_word_c[FRAME_BITS-1];
          ldac_n_d = 1'b1;
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          cnt_d   = CNT_W'(CLK_DIV - 1);
          bit_d   = BIT_W'(FRAME_BITS - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (sclk_q) begin
          // Falling edge: advance data unless this was the last bit
          sclk_d = 1'b0;
          cnt_d  = CNT_W'(CLK_DIV - 1);
          if (bit_q != '0) begin
            shift_d = shifted_c;
            mosi_d  = shifted_c[FRAME_BITS-1];
          end
        end else if (bit_q == '0) begin
          state_d     = ST_LDAC;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          ldac_n_d    = 1'b0;
          cnt_d       = CNT_W'(LDAC_CYCLES - 1);
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end else begin
          sclk_d = 1'b1;
          bit_d  = bit_q - BIT_W'(1);
          cnt_d  = CNT_W'(CLK_DIV - 1);
        end
      end

      ST_LDAC: begin
        if (cnt_q == '0) begin
          state_d  = ST_GAP;
          ldac_n_d = 1'b1;
          cnt_d    = CNT_W'(CS_GAP - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        sclk_d   = 1'b0;
        cs_n_d   = 1'b1;
        mosi_d   = 1'b0;
        ldac_n_d = 1'b1;
      end
    endcase

    // A pending word is consumed when IDLE launches it
    if ((state_q == ST_IDLE) && pending_q) begin
      pending_d = 1'b0;
    end

    // Clear first so a coincident new overrun wins
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    // Triggers that cannot launch directly are parked; losing one flags overrun
    if (trig_c && !direct_ok_c) begin
      pending_d   = 1'b1;
      pend_word_d = payload_c;
      if (pending_q && (state_q != ST_IDLE)) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Busy covers both an active frame and a parked trigger
  assign busy_d = (state_d != ST_IDLE) || pending_d;

  assign dac_sclk   = sclk_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_mosi   = mosi_q;
  assign dac_ldac_n = ldac_n_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pio_dac_spi_tx.sv
// Directed bench for pio_dac_spi_tx: default instance A plus a fast,
// narrow-counter instance B for wrap and back-to-back spacing.
module tb_pio_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] pio_a, pio_b;
  logic        clr_a, clr_b;

  logic        sclk_a, cs_a, mosi_a, ldac_a, busy_a, ovr_a;
  logic [15:0] fcnt_a;
  logic        sclk_b, cs_b, mosi_b, ldac_b, busy_b, ovr_b;
  logic [3:0]  fcnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pio_dac_spi_tx u_a (
    .clk(clk), .reset(rst_a), .pio_word(pio_a), .overrun_clr(clr_a),
    .dac_sclk(sclk_a), .dac_cs_n(cs_a), .dac_mosi(mosi_a), .dac_ldac_n(ldac_a),
    .busy(busy_a), .overrun(ovr_a), .frame_cnt(fcnt_a)
  );

  pio_dac_spi_tx #(
    .CLK_DIV(1), .FRAME_BITS(24), .LDAC_CYCLES(1), .CS_GAP(1), .FRAME_CNT_W(4)
  ) u_b (
    .clk(clk), .reset(rst_b), .pio_word(pio_b), .overrun_clr(clr_b),
    .dac_sclk(sclk_b), .dac_cs_n(cs_b), .dac_mosi(mosi_b), .dac_ldac_n(ldac_b),
    .busy(busy_b), .overrun(ovr_b), .frame_cnt(fcnt_b)
  );

  // Instance A SPI observer: frame length, SCLK rising edges, captured bits, LDAC width
  logic        a_cs_p = 1'b1, a_sclk_p = 1'b0, a_ldac_p = 1'b1;
  int          a_len = 0, a_rises = 0, a_falls = 0, a_frames = 0;
  int          a_last_len = 0, a_last_rises = 0, a_ldac_run = 0, a_last_ldac = 0;
  logic [31:0] a_cap = '0, a_last_cap = '0;

  always @(posedge clk) begin
    a_cs_p   <= cs_a;
    a_sclk_p <= sclk_a;
    a_ldac_p <= ldac_a;
    if (a_cs_p && !cs_a) begin
      a_falls <= a_falls + 1;
      a_len   <= 1;
      a_rises <= 0;
      a_cap   <= '0;
    end else if (!cs_a) begin
      a_len <= a_len + 1;
      if (sclk_a && !a_sclk_p) begin
        a_rises <= a_rises + 1;
        a_cap   <= {a_cap[30:0], mosi_a};
      end
    end
    if (!a_cs_p && cs_a) begin
      a_frames     <= a_frames + 1;
      a_last_len   <= a_len;
      a_last_rises <= a_rises;
      a_last_cap   <= a_cap;
    end
    if (!ldac_a) begin
      a_ldac_run <= a_ldac_run + 1;
    end else if (!a_ldac_p) begin
      a_last_ldac <= a_ldac_run;
      a_ldac_run  <= 0;
    end
  end

  // Instance B observer: frame starts, captured bits, minimum cs_n high run between frames
  logic        b_cs_p = 1'b1, b_sclk_p = 1'b0;
  int          b_falls = 0, b_hi_run = 0, b_min_hi = 1000;
  logic [31:0] b_cap = '0, b_last_cap = '0;

  always @(posedge clk) begin
    b_cs_p   <= cs_b;
    b_sclk_p <= sclk_b;
    if (cs_b) begin
      b_hi_run <= b_hi_run + 1;
    end else if (b_cs_p) begin
      if (b_falls > 0 && b_hi_run < b_min_hi) b_min_hi <= b_hi_run;
      b_hi_run <= 0;
      b_falls  <= b_falls + 1;
      b_cap    <= '0;
    end else if (sclk_b && !b_sclk_p) begin
      b_cap <= {b_cap[30:0], mosi_b};
    end
    if (!b_cs_p && cs_b) b_last_cap <= b_cap;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int n = 0;
    while (busy_a !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  logic b_bit = 1'b1;
  task automatic toggle_b(input int k);
    b_bit = ~b_bit;
    pio_b = {b_bit, 7'h0, 24'(32'h100 + k)};
  endtask

  initial begin
    int f0;
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    pio_a = 32'hFFFF_FFFF; pio_b = 32'hFFFF_FFFF;
    clr_a = 1'b0; clr_b = 1'b0;
    tick(3);

    // Reset values
    check("rst_cs_n",   32'(cs_a),   32'd1);
    check("rst_sclk",   32'(sclk_a), 32'd0);
    check("rst_mosi",   32'(mosi_a), 32'd0);
    check("rst_ldac_n", 32'(ldac_a), 32'd1);
    check("rst_busy",   32'(busy_a), 32'd0);
    check("rst_ovr",    32'(ovr_a),  32'd0);
    check("rst_fcnt",   32'(fcnt_a), 32'd0);

    // 1: release with all-ones PIO -> no frame
    rst_a = 1'b0; rst_b = 1'b0;
    tick(1000);
    check("t1_no_cs_fall", 32'(a_falls), 32'd0);
    check("t1_fcnt",       32'(fcnt_a),  32'd0);
    check("t1_busy",       32'(busy_a),  32'd0);

    // 2: single frame 0x123456
    pio_a = 32'h0012_3456;
    tick(1);
    check("t2_busy_rise", 32'(busy_a), 32'd1);
    check("t2_cs_low",    32'(cs_a),   32'd0);
    tick(199);
    check("t2_busy_199", 32'(busy_a), 32'd1);
    tick(1);
    check("t2_busy_fall",  32'(busy_a),       32'd0);
    check("t2_cs_len",     32'(a_last_len),   32'd196);
    check("t2_rises",      32'(a_last_rises), 32'd24);
    check("t2_data",       a_last_cap,        32'h0012_3456);
    check("t2_ldac_width", 32'(a_last_ldac),  32'd2);
    check("t2_fcnt",       32'(fcnt_a),       32'd1);
    check("t2_ovr",        32'(ovr_a),        32'd0);

    // 3: second toggle mid-frame queues ABCDEF, launched one cycle after IDLE
    pio_a = 32'h8065_4321;
    tick(1);
    tick(49);
    pio_a = 32'h00AB_CDEF;
    tick(151);
    check("t3_gap_cs",   32'(cs_a),   32'd1);
    check("t3_gap_busy", 32'(busy_a), 32'd1);
    check("t3_gap_ldac", 32'(ldac_a), 32'd1);
    tick(1);
    check("t3_next_cs",   32'(cs_a),  32'd0);
    check("t3_first_data", a_last_cap, 32'h0065_4321);
    tick(200);
    check("t3_busy_fall", 32'(busy_a), 32'd0);
    check("t3_data",      a_last_cap,  32'h00AB_CDEF);
    check("t3_fcnt",      32'(fcnt_a), 32'd3);
    check("t3_ovr",       32'(ovr_a),  32'd0);

    // 4: two toggles in one frame -> last wins and overrun set
    f0 = a_frames;
    pio_a = 32'h8000_0000;
    tick(20);
    pio_a = 32'h0000_0001;
    tick(20);
    check("t4_ovr_before", 32'(ovr_a), 32'd0);
    pio_a = 32'h8000_0002;
    tick(1);
    check("t4_ovr_set", 32'(ovr_a), 32'd1);
    wait_idle_a("t4_idle_timeout", 600);
    check("t4_frames", 32'(a_frames - f0), 32'd2);
    check("t4_data",   a_last_cap,         32'h0000_0002);
    check("t4_fcnt",   32'(fcnt_a),        32'd5);
    check("t4_ovr_sticky", 32'(ovr_a), 32'd1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("t4_ovr_clr", 32'(ovr_a), 32'd0);
    pio_a = 32'h0000_0010;
    tick(10);
    pio_a = 32'h8000_0011;
    tick(10);
    pio_a = 32'h0000_0012;
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("t4_set_wins", 32'(ovr_a), 32'd1);
    wait_idle_a("t4b_idle_timeout", 600);
    check("t4b_fcnt", 32'(fcnt_a), 32'd7);
    check("t4b_data", a_last_cap,  32'h0000_0012);

    // 5: reset in the middle of bit 10
    pio_a = 32'h8055_AAAA;
    tick(1);
    tick(85);
    check("t5_mid_sclk", 32'(sclk_a), 32'd1);
    check("t5_mid_cs",   32'(cs_a),   32'd0);
    rst_a = 1'b1;
    #1;
    check("t5_rst_cs",   32'(cs_a),   32'd1);
    check("t5_rst_sclk", 32'(sclk_a), 32'd0);
    check("t5_rst_ldac", 32'(ldac_a), 32'd1);
    check("t5_rst_busy", 32'(busy_a), 32'd0);
    tick(3);
    rst_a = 1'b0;
    f0 = a_falls;
    tick(100);
    check("t5_no_frame", 32'(a_falls - f0), 32'd0);
    check("t5_fcnt0",    32'(fcnt_a),       32'd0);
    check("t5_idle",     32'(busy_a),       32'd0);
    pio_a = 32'h0013_5799;
    tick(1);
    check("t5_busy", 32'(busy_a), 32'd1);
    wait_idle_a("t5_idle_timeout", 400);
    check("t5_fcnt1", 32'(fcnt_a), 32'd1);
    check("t5_data",  a_last_cap,  32'h0013_5799);

    // 6: 17 back-to-back frames on the narrow counter instance
    toggle_b(1);
    for (int i = 1; i <= 16; i++) begin
      n = 0;
      while (b_falls < i && n < 200) begin
        tick(1);
        n++;
      end
      check("t6_start_timeout", 32'(n < 200), 32'd1);
      if (i == 16) check("t6_fcnt15", 32'(fcnt_b), 32'd15);
      toggle_b(i + 1);
    end
    n = 0;
    while (b_falls < 17 && n < 200) begin
      tick(1);
      n++;
    end
    check("t6_start17_timeout", 32'(n < 200), 32'd1);
    check("t6_fcnt_wrap0", 32'(fcnt_b), 32'd0);
    n = 0;
    while (busy_b !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    check("t6_idle_timeout", 32'(n < 200), 32'd1);
    check("t6_fcnt_wrap1", 32'(fcnt_b),   32'd1);
    check("t6_min_cs_hi",  32'(b_min_hi), 32'd3);
    check("t6_ovr",        32'(ovr_b),    32'd0);
    check("t6_data",       b_last_cap,    32'h0000_0111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
